// File: rtl/core_pkg.sv
// core_pkg: definitions shared by the memory-port arbiter and its helper.
//   arb_state_t         : arbiter FSM state (IDLE, FETCH, DATA)
//   ADDR_W_DEF/DATA_W_DEF : default byte-address and data widths
package core_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_req_reg.sv
// mem_req_reg: holding register for the granted memory request fields.
// Loaded once per grant and held stable for the rest of the transaction.
//   clk, reset          : core clock, synchronous active-high reset
//   load                : capture next_* this cycle
//   next_we/addr/wdata/be : request fields selected by the arbiter
//   we/addr/wdata/be    : registered fields driven onto the memory port
module mem_req_reg
  import core_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                next_we,
  input  logic [ADDR_W-1:0]   next_addr,
  input  logic [DATA_W-1:0]   next_wdata,
  input  logic [DATA_W/8-1:0] next_be,
  output logic                we,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] be
);

  always_ff @(posedge clk) begin
    if (reset) begin
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      be    <= '0;
    end else if (load) begin
      we    <= next_we;
      addr  <= next_addr;
      wdata <= next_wdata;
      be    <= next_be;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the single memory port between instruction fetch
// and the data-memory stage, one outstanding transaction at a time.
//   clk, reset                        : core clock, synchronous active-high reset
//   if_req/if_addr/if_kill            : fetch request, address, flush kill pulse
//   if_rdata/if_valid                 : fetched word and one-cycle completion
//   dm_req/dm_we/dm_addr/dm_wdata/dm_be : data request
//   dm_rdata/dm_valid                 : load data and one-cycle completion
//   stall_if/stall_mem                : requester stalls for the hazard unit
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be : registered memory request
//   mem_rdata/mem_ready               : memory response
module mem_port_arbiter
  import core_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_kill,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_be,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_valid,
  output logic                stall_if,
  output logic                stall_mem,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ready
);

  arb_state_t          state;
  logic                kill_pend;
  logic                if_elig, dm_elig, grant;
  logic                next_we;
  logic [ADDR_W-1:0]   next_addr;
  logic [DATA_W-1:0]   next_wdata;
  logic [DATA_W/8-1:0] next_be;

  // While a requester's valid is high its request line still refers to the
  // transaction just completed, so it must not be granted again.
  always_comb begin
    dm_elig    = dm_req && !dm_valid;
    if_elig    = if_req && !if_valid;
    grant      = (state == IDLE) && (dm_elig || if_elig);
    // Data wins: it belongs to the older instruction.
    next_we    = dm_elig ? dm_we    : 1'b0;
    next_addr  = dm_elig ? dm_addr  : if_addr;
    next_wdata = dm_elig ? dm_wdata : '0;
    next_be    = dm_elig ? dm_be    : '1;
  end

  assign stall_if  = if_req && !if_valid;
  assign stall_mem = dm_req && !dm_valid;

  mem_req_reg #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (grant),
    .next_we    (next_we),
    .next_addr  (next_addr),
    .next_wdata (next_wdata),
    .next_be    (next_be),
    .we         (mem_we),
    .addr       (mem_addr),
    .wdata      (mem_wdata),
    .be         (mem_be)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      if_valid  <= 1'b0;
      dm_valid  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      kill_pend <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          // Stray mem_ready here is ignored.
          if (dm_elig) begin
            state   <= DATA;
            mem_req <= 1'b1;
          end else if (if_elig) begin
            state   <= FETCH;
            mem_req <= 1'b1;
          end
        end
        FETCH: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            kill_pend <= 1'b0;
            // A kill on the completing cycle counts as well as an earlier one.
            if (!(kill_pend || if_kill)) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end else if (if_kill) begin
            kill_pend <= 1'b1;
          end
        end
        DATA: begin
          if (mem_ready) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            dm_valid <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single unified memory port of the pipelined RISC-V core between the instruction-fetch stage and the data-memory stage, one outstanding transaction at a time. It raises per-requester stall signals that the hazard unit ORs into StallF/StallD and the M-stage hold. It also honours fetch kills from branch/JALR flushes.

## Interface
Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, data width; byte enables are DATA_W/8 bits

Ports:
- clk  in  1  core clock; only clock
- reset  in  1  synchronous, active-high
- if_req  in  1  fetch request, level, held until if_valid
- if_addr  in  ADDR_W  fetch address, stable while if_req
- if_kill  in  1  pulse; discard in-flight/pending fetch (driven by FlushD)
- if_rdata  out  DATA_W  fetched instruction, valid with if_valid
- if_valid  out  1  one-cycle completion pulse for fetch
- dm_req  in  1  data request, level, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_be  in  DATA_W/8  store byte enables
- dm_rdata  out  DATA_W  load data, valid with dm_valid
- dm_valid  out  1  one-cycle completion pulse for data
- stall_if  out  1  if_req && !if_valid
- stall_mem  out  1  dm_req && !dm_valid
- mem_req  out  1  memory request, held until mem_ready
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_W/DATA_W/DATA_W/8  registered copy of granted request
- mem_rdata  in  DATA_W  read data, valid when mem_ready
- mem_ready  in  1  transaction complete this cycle

## Operation
- States: IDLE, FETCH, DATA.
- IDLE: if dm_req is eligible, latch the dm_* fields and go to DATA. Otherwise, if if_req is eligible, latch if_addr (we=0, be=all ones) and go to FETCH. Otherwise stay in IDLE. Data has fixed priority because it is the older instruction.
- Eligibility: a requester is not eligible in the cycle its own valid is high. The request line in that cycle belongs to the completed transaction.
- FETCH/DATA: mem_req=1 with latched fields, held stable. On mem_ready, capture mem_rdata into the matching rdata register, pulse the matching valid next cycle, and return to IDLE.
- Kill: if_kill sets kill_pend while in FETCH, or in the same cycle as the FETCH mem_ready. The transaction still completes on the bus, but if_valid is suppressed and if_rdata is not updated. kill_pend clears when FETCH exits.
- if_kill in IDLE or DATA has no effect. A new fetch request after a kill is arbitrated normally.
- Stores: dm_valid pulses and dm_rdata holds its previous value.
- stall_if and stall_mem are combinational from the request inputs and valid registers.

## Timing
- Reset values: state=IDLE, mem_req=0, mem_* fields=0, if_valid=0, dm_valid=0, if_rdata=0, dm_rdata=0, kill_pend=0.
- Latency with zero-wait memory: request seen in IDLE at cycle N, mem_req high at N+1 (mem_ready at N+1), valid at N+2. Each memory wait cycle adds one cycle.
- Back-to-back: the valid cycle is also the return to IDLE, so the next grant is sampled in that cycle. Throughput is one transaction per 2 cycles with zero-wait memory.
- Simultaneous if_req and dm_req in IDLE: DATA is granted first and FETCH follows. Fetch waits at most one data transaction.
- Reset mid-transaction: next cycle state=IDLE, mem_req=0, no valid pulse. The memory shares the reset and abandons the access.
- mem_ready while in IDLE is ignored.

## Structure
- Shared package (core_pkg): state enum arb_state_t {IDLE, FETCH, DATA}, and the ADDR_W/DATA_W defaults.
- Single module; no sub-module required. An optional small request-latch helper, mem_req_reg, may hold mem_* fields.
- Hazard unit integration: StallF/StallD |= stall_if | stall_mem; the M-stage hold = stall_mem.

## Test plan
- Lone fetch, zero-wait memory: if_req at cycle 1 with addr 0x100 -> mem_req at 2 with mem_addr 0x100; mem_rdata 0x00500093 -> if_valid=1 at 3 with if_rdata 0x00500093; stall_if=1 at 1–2, 0 at 3.
- Contention: if_req and dm_req (load 0x2000) both at cycle 1 -> DATA granted first, dm_valid at 3, FETCH mem_req at 4, if_valid at 5.
- Wait states: store to 0x3000, be=4'b0011, with mem_ready delayed 3 cycles -> mem_* fields stable throughout; dm_valid exactly one cycle; dm_rdata unchanged.
- Kill: if_kill pulse one cycle after a FETCH grant, with mem_ready two cycles later -> no if_valid and if_rdata unchanged. A subsequent fetch of 0x200 completes normally.
- Kill coincident with mem_ready -> if_valid suppressed.
- Reset asserted mid-DATA with mem_ready low -> next cycle state IDLE, mem_req=0, no valid pulses. Then a fresh fetch completes with the nominal 2-cycle latency.
